select_begin_end: RTL

//  Consumes the snapped city coordinates produced by the mouse hit-detector (pos_x/pos_y, zero = no hit).

---
 rtl/city_pkg.sv | 47 ++++
 rtl/city_lookup.sv | 41 ++++
 rtl/select_begin_end.sv | 131 +++++++++++++
 3 files changed

// File: rtl/city_pkg.sv
// City coordinate tables, FSM state type and the marker distance helper shared by
// the begin/end selection logic. The node ID of a city is its index in the tables.
package city_pkg;

  localparam int NUM_CITIES = 46;
  localparam int CITY_ID_W  = 6;
  localparam int COORD_W    = 10;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [CITY_ID_W-1:0] city_id_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_END,
    REQ,
    DONE
  } state_t;

  // Snapped city centres. Entries 7 and 8 are close enough that their markers overlap.
  localparam coord_t CITY_X [NUM_CITIES] = '{
    10'd120, 10'd210, 10'd340, 10'd465, 10'd580, 10'd90,  10'd400, 10'd530,
    10'd535, 10'd610, 10'd150, 10'd250, 10'd60,  10'd180, 10'd320, 10'd440,
    10'd560, 10'd620, 10'd80,  10'd230, 10'd370, 10'd500, 10'd600, 10'd140,
    10'd290, 10'd420, 10'd520, 10'd300, 10'd360, 10'd480, 10'd200, 10'd100,
    10'd40,  10'd270, 10'd390, 10'd460, 10'd550, 10'd630, 10'd30,  10'd170,
    10'd340, 10'd600, 10'd110, 10'd260, 10'd480, 10'd620
  };

  localparam coord_t CITY_Y [NUM_CITIES] = '{
    10'd80,  10'd95,  10'd140, 10'd186, 10'd120, 10'd210, 10'd260, 10'd301,
    10'd304, 10'd240, 10'd300, 10'd220, 10'd350, 10'd400, 10'd380, 10'd350,
    10'd390, 10'd330, 10'd440, 10'd460, 10'd450, 10'd440, 10'd450, 10'd150,
    10'd60,  10'd70,  10'd40,  10'd297, 10'd200, 10'd240, 10'd340, 10'd260,
    10'd120, 10'd140, 10'd320, 10'd410, 10'd180, 10'd90,  10'd30,  10'd30,
    10'd30,  10'd30,  10'd380, 10'd400, 10'd470, 10'd470
  };

  // |draw - centre| <= r, evaluated one bit wider and signed so pixels near 0 never wrap.
  function automatic logic within_mark(input coord_t draw, input coord_t centre, input int r);
    logic signed [COORD_W:0] diff;
    logic signed [COORD_W:0] lim;
    diff = $signed({1'b0, draw}) - $signed({1'b0, centre});
    lim  = (COORD_W+1)'(r);
    return (diff >= -lim) && (diff <= lim);
  endfunction

endpackage

// File: rtl/city_lookup.sv
// Stage 2 of the hit pipeline: exact-match the stage-1 coordinates against every
// city entry and register the matched event together with its node index.
module city_lookup
  import city_pkg::*;
(
  input  logic     Clk,
  input  logic     Reset_N,
  input  coord_t   x,
  input  coord_t   y,
  input  logic     cand,
  output logic     evt,
  output city_id_t idx
);

  logic     match;
  city_id_t match_idx;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NUM_CITIES; i++) begin
      if (x == CITY_X[i] && y == CITY_Y[i]) begin
        match     = 1'b1;
        match_idx = city_id_t'(i);
      end
    end
  end

  // An edge that lands on no city is dropped here without trace.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      evt <= 1'b0;
      idx <= '0;
    end else begin
      evt <= cand & match;
      idx <= match_idx;
    end
  end

endmodule

// File: rtl/select_begin_end.sv
// Turns mouse hits on cities into a BEGIN/END node pair, hands the pair to the
// path engine over valid/ready, and draws square markers around the chosen cities.
module select_begin_end
  import city_pkg::*;
#(
  parameter int MARK_R = 3
) (
  input  logic           Clk,
  input  logic           Reset_N,
  input  logic [9:0]     pos_x_in,
  input  logic [9:0]     pos_y_in,
  input  logic           clear,
  input  logic [9:0]     DrawX,
  input  logic [9:0]     DrawY,
  output logic [5:0]     begin_id,
  output logic [5:0]     end_id,
  output logic           begin_vld,
  output logic           end_vld,
  output logic           path_req_valid,
  input  logic           path_req_ready,
  output logic           marker_on,
  output logic           marker_is_end
);

  // Stage 1: rising edge of "hit" so a held button produces one event.
  logic   hit;
  logic   hit_d;
  logic   s1_cand;
  coord_t s1_x;
  coord_t s1_y;

  assign hit = (pos_x_in != '0) && (pos_y_in != '0);

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      hit_d   <= 1'b0;
      s1_cand <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hit_d   <= hit;
      s1_cand <= hit & ~hit_d;
      s1_x    <= pos_x_in;
      s1_y    <= pos_y_in;
    end
  end

  logic     s2_evt;
  city_id_t s2_idx;

  city_lookup u_lookup (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .x       (s1_x),
    .y       (s1_y),
    .cand    (s1_cand),
    .evt     (s2_evt),
    .idx     (s2_idx)
  );

  state_t   state, state_nxt;
  city_id_t begin_id_nxt, end_id_nxt;
  logic     begin_vld_nxt, end_vld_nxt;

  always_comb begin
    state_nxt     = state;
    begin_id_nxt  = begin_id;
    end_id_nxt    = end_id;
    begin_vld_nxt = begin_vld;
    end_vld_nxt   = end_vld;
    if (clear) begin
      // IDs keep their stale values; only the flags say whether they mean anything.
      state_nxt     = IDLE;
      begin_vld_nxt = 1'b0;
      end_vld_nxt   = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (s2_evt) begin
          begin_id_nxt  = s2_idx;
          begin_vld_nxt = 1'b1;
          state_nxt     = WAIT_END;
        end
        WAIT_END: if (s2_evt && s2_idx != begin_id) begin
          end_id_nxt  = s2_idx;
          end_vld_nxt = 1'b1;
          state_nxt   = REQ;
        end
        REQ: if (path_req_ready) state_nxt = DONE;
        DONE: if (s2_evt) begin
          begin_id_nxt = s2_idx;
          end_vld_nxt  = 1'b0;
          state_nxt    = WAIT_END;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= IDLE;
      begin_id  <= '0;
      end_id    <= '0;
      begin_vld <= 1'b0;
      end_vld   <= 1'b0;
    end else begin
      state     <= state_nxt;
      begin_id  <= begin_id_nxt;
      end_id    <= end_id_nxt;
      begin_vld <= begin_vld_nxt;
      end_vld   <= end_vld_nxt;
    end
  end

  // Decoded from the state register, so an async reset withdraws the request at once.
  assign path_req_valid = (state == REQ);

  logic begin_hit, end_hit;

  assign begin_hit = begin_vld
                   && within_mark(DrawX, CITY_X[begin_id], MARK_R)
                   && within_mark(DrawY, CITY_Y[begin_id], MARK_R);
  assign end_hit   = end_vld
                   && within_mark(DrawX, CITY_X[end_id], MARK_R)
                   && within_mark(DrawY, CITY_Y[end_id], MARK_R);

  assign marker_on     = begin_hit | end_hit;
  assign marker_is_end = end_hit;

endmodule
